// File: rtl/aes_block_host.sv
// Host-side sequencer for an external AES-128 core: accepts one block at a time,
// applies ECB/CBC chaining around the core and watches for a core that never completes.
module aes_block_host #(
    parameter int unsigned TIMEOUT = 48
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         CFG_LOAD,
    input  logic [127:0] KEY,
    input  logic [127:0] IV,
    input  logic         MODE,
    input  logic         ENCDEC,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [127:0] IN_DATA,
    input  logic         IN_LAST,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [127:0] OUT_DATA,
    output logic         OUT_LAST,
    output logic         ERR,
    output logic         CORE_START,
    output logic         CORE_ENCDEC,
    output logic [127:0] CORE_KEY,
    output logic [127:0] CORE_TEXTIN,
    input  logic         CORE_DONE,
    input  logic [127:0] CORE_TEXTOUT
);

    localparam int unsigned BLK_W = 128;
    localparam int unsigned CNT_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_OUT,
        ST_ERROR
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [BLK_W-1:0]   key_q, iv_q, chain_q, blk_q, textin_q, out_data_q;
    logic               mode_q, encdec_q, last_q, out_last_q;
    logic               rdy_q, start_q, ovalid_q, err_q;
    logic               cfg_fire, in_fire, out_fire, done_fire, timeout_hit;
    logic               cbc_enc, cbc_dec;
    logic [BLK_W-1:0]   textin_d, result_d;

    // A config strobe always wins over a block offered in the same cycle.
    assign IN_READY    = rdy_q & ~CFG_LOAD;
    assign cfg_fire    = CFG_LOAD && (state_q == ST_IDLE);
    assign in_fire     = IN_VALID && IN_READY;
    assign out_fire    = ovalid_q && OUT_READY;
    assign done_fire   = CORE_DONE && (state_q == ST_WAIT);
    // cnt_q + 1 cycles have elapsed since START; ERR then rises exactly TIMEOUT cycles after START.
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 2));

    assign cbc_enc  = mode_q & ~encdec_q;
    assign cbc_dec  = mode_q & encdec_q;
    assign textin_d = cbc_enc ? (IN_DATA ^ chain_q) : IN_DATA;
    assign result_d = cbc_dec ? (CORE_TEXTOUT ^ chain_q) : CORE_TEXTOUT;

    assign OUT_VALID   = ovalid_q;
    assign OUT_DATA    = out_data_q;
    assign OUT_LAST    = out_last_q;
    assign ERR         = err_q;
    assign CORE_START  = start_q;
    assign CORE_ENCDEC = encdec_q;
    assign CORE_KEY    = key_q;
    assign CORE_TEXTIN = textin_q;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (in_fire) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (CORE_DONE)        state_d = ST_OUT;
                else if (timeout_hit) state_d = ST_ERROR;
            end
            ST_OUT:   if (OUT_READY) state_d = ST_IDLE;
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register and status outputs, registered from the next state.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= ST_IDLE;
            rdy_q    <= 1'b0;
            start_q  <= 1'b0;
            ovalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_q    <= (state_d == ST_IDLE);
            start_q  <= (state_d == ST_ISSUE);
            ovalid_q <= (state_d == ST_OUT);
            err_q    <= (state_d == ST_ERROR);
        end
    end

    // Watchdog counter: cleared while issuing, counts while waiting on the core.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= '0;
        end else if (state_q == ST_ISSUE) begin
            cnt_q <= '0;
        end else if (state_q == ST_WAIT) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Configuration, captured block and core request.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            key_q    <= '0;
            iv_q     <= '0;
            mode_q   <= 1'b0;
            encdec_q <= 1'b0;
            blk_q    <= '0;
            last_q   <= 1'b0;
            textin_q <= '0;
        end else begin
            if (cfg_fire) begin
                key_q    <= KEY;
                iv_q     <= IV;
                mode_q   <= MODE;
                encdec_q <= ENCDEC;
            end
            if (in_fire) begin
                blk_q    <= IN_DATA;
                last_q   <= IN_LAST;
                textin_q <= textin_d;
            end
        end
    end

    // Result capture and CBC chain register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            chain_q    <= '0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            if (done_fire) begin
                out_data_q <= result_d;
                out_last_q <= last_q;
            end
            if (cfg_fire) begin
                chain_q <= IV;
            end else if (done_fire && mode_q) begin
                chain_q <= encdec_q ? blk_q : CORE_TEXTOUT;
            end else if (out_fire && out_last_q) begin
                chain_q <= iv_q;
            end
        end
    end

endmodule

// File: tb/tb_aes_block_host.sv
// Bench for aes_block_host: behavioural AES core stub plus a message-level ECB/CBC reference model.
module tb_aes_block_host;

    localparam int unsigned TIMEOUT = 48;

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] Q1  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] Q2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] D1  = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] D2  = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] MIX = 128'hc3a5_5a3c_0f1e_e1f0_9669_6996_1234_fedc;

    // Known AES-128 pairs; CBC entries are keyed on the XOR-ed core input.
    localparam logic [127:0] TAB_K [3] = '{K1, K2, K2};
    localparam logic [127:0] TAB_P [3] = '{P1, Q1 ^ IV2, Q2 ^ D1};
    localparam logic [127:0] TAB_C [3] = '{C1, D1, D2};

    logic         CLK = 1'b0;
    logic         nRST;
    logic         CFG_LOAD;
    logic [127:0] KEY, IV;
    logic         MODE, ENCDEC;
    logic         IN_VALID, IN_READY;
    logic [127:0] IN_DATA;
    logic         IN_LAST;
    logic         OUT_VALID, OUT_READY;
    logic [127:0] OUT_DATA;
    logic         OUT_LAST;
    logic         ERR;
    logic         CORE_START, CORE_ENCDEC;
    logic [127:0] CORE_KEY, CORE_TEXTIN;
    logic         CORE_DONE;
    logic [127:0] CORE_TEXTOUT;

    int n_checks = 0;
    int n_fail   = 0;
    int core_lat = 5;
    bit core_hang = 1'b0;
    int start_count = 0;

    logic [127:0] m_key, m_iv, m_chain;
    logic         m_mode, m_dec;

    aes_block_host #(.TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .nRST(nRST), .CFG_LOAD(CFG_LOAD), .KEY(KEY), .IV(IV),
        .MODE(MODE), .ENCDEC(ENCDEC), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_DATA(IN_DATA), .IN_LAST(IN_LAST), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_DATA(OUT_DATA), .OUT_LAST(OUT_LAST), .ERR(ERR), .CORE_START(CORE_START),
        .CORE_ENCDEC(CORE_ENCDEC), .CORE_KEY(CORE_KEY), .CORE_TEXTIN(CORE_TEXTIN),
        .CORE_DONE(CORE_DONE), .CORE_TEXTOUT(CORE_TEXTOUT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Stand-in cipher: exact AES for the published vectors, an invertible mix otherwise.
    function automatic logic [127:0] core_model(input logic [127:0] k, input logic [127:0] x, input logic dec);
        logic [127:0] y;
        for (int i = 0; i < 3; i++) begin
            if (k == TAB_K[i] && !dec && x == TAB_P[i]) return TAB_C[i];
            if (k == TAB_K[i] &&  dec && x == TAB_C[i]) return TAB_P[i];
        end
        if (!dec) return {x[126:0], x[127]} ^ k ^ MIX;
        y = x ^ k ^ MIX;
        return {y[0], y[127:1]};
    endfunction

    // Message-level ECB/CBC model; the chain restarts from IV after a LAST block.
    task automatic model_block(input logic [127:0] x, input logic last, output logic [127:0] r);
        if (!m_mode) begin
            r = core_model(m_key, x, m_dec);
        end else if (!m_dec) begin
            r = core_model(m_key, x ^ m_chain, 1'b0);
            m_chain = r;
        end else begin
            r = core_model(m_key, x, 1'b1) ^ m_chain;
            m_chain = x;
        end
        if (last) m_chain = m_iv;
    endtask

    // Core stub: answers each START after core_lat cycles, drives garbage TEXTOUT otherwise.
    initial begin
        logic [127:0] sk, sx;
        logic         sd;
        bit           aborted;
        CORE_DONE = 1'b0;
        CORE_TEXTOUT = '0;
        forever begin
            @(negedge CLK);
            CORE_TEXTOUT = rnd128();
            if (nRST === 1'b1 && CORE_START === 1'b1) begin
                start_count++;
                if (!core_hang) begin
                    sk = CORE_KEY; sx = CORE_TEXTIN; sd = CORE_ENCDEC; aborted = 1'b0;
                    for (int i = 0; i < core_lat; i++) begin
                        @(negedge CLK);
                        CORE_TEXTOUT = rnd128();
                        if (nRST !== 1'b1) begin
                            aborted = 1'b1;
                            break;
                        end
                        n_checks++;
                        if ({CORE_TEXTIN, CORE_KEY, CORE_ENCDEC} !== {sx, sk, sd}) begin
                            n_fail++;
                            $display("FAIL core_inputs_hold: got textin=%h key=%h encdec=%b required textin=%h key=%h encdec=%b",
                                     CORE_TEXTIN, CORE_KEY, CORE_ENCDEC, sx, sk, sd);
                        end
                    end
                    if (!aborted) begin
                        CORE_DONE = 1'b1;
                        CORE_TEXTOUT = core_model(sk, sx, sd);
                        @(negedge CLK);
                        CORE_DONE = 1'b0;
                        CORE_TEXTOUT = rnd128();
                    end
                end
            end
        end
    end

    task automatic cfg(input logic [127:0] k, input logic [127:0] iv, input logic m, input logic d);
        @(negedge CLK);
        CFG_LOAD = 1'b1; KEY = k; IV = iv; MODE = m; ENCDEC = d;
        @(negedge CLK);
        CFG_LOAD = 1'b0;
        m_key = k; m_iv = iv; m_chain = iv; m_mode = m; m_dec = d;
    endtask

    // Offers one block; returns at the negedge after acceptance (the ISSUE cycle).
    task automatic send(input logic [127:0] x, input logic l);
        int n;
        n = 0;
        @(negedge CLK);
        IN_VALID = 1'b1; IN_DATA = x; IN_LAST = l;
        #1;
        while (IN_READY !== 1'b1) begin
            n++;
            if (n > 200) begin
                n_checks++; n_fail++;
                $display("FAIL send_timeout: IN_READY=%b after %0d cycles, required 1", IN_READY, n);
                break;
            end
            @(negedge CLK);
            #1;
        end
        @(negedge CLK);
        IN_VALID = 1'b0; IN_DATA = rnd128();
    endtask

    task automatic recv(input int dly, output logic [127:0] d, output logic l);
        int n;
        n = 0;
        d = 'x; l = 1'bx;
        while (OUT_VALID !== 1'b1) begin
            n++;
            if (n > 200) begin
                n_checks++; n_fail++;
                $display("FAIL recv_timeout: OUT_VALID=%b after %0d cycles, required 1", OUT_VALID, n);
                return;
            end
            @(negedge CLK);
        end
        repeat (dly) @(negedge CLK);
        d = OUT_DATA; l = OUT_LAST;
        OUT_READY = 1'b1;
        @(negedge CLK);
        OUT_READY = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        repeat (2) @(negedge CLK);
        n_checks++;
        if ({IN_READY, OUT_VALID, ERR, CORE_START, CORE_ENCDEC, OUT_LAST} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 000000",
                     {IN_READY, OUT_VALID, ERR, CORE_START, CORE_ENCDEC, OUT_LAST});
        end
        n_checks++;
        if ({OUT_DATA, CORE_KEY, CORE_TEXTIN} !== 384'b0) begin
            n_fail++;
            $display("FAIL reset_data: got out=%h key=%h textin=%h required all zero", OUT_DATA, CORE_KEY, CORE_TEXTIN);
        end
        nRST = 1'b1;
        @(negedge CLK);
        n_checks++;
        if ({IN_READY, CORE_START, OUT_VALID} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_release: got ready/start/valid=%b required 100", {IN_READY, CORE_START, OUT_VALID});
        end
    endtask

    task automatic test_vectors();
        logic [127:0] got;
        logic         gl;
        cfg(K1, '0, 1'b0, 1'b0);
        send(P1, 1'b1); recv(0, got, gl);
        n_checks++;
        if ({got, gl} !== {C1, 1'b1}) begin n_fail++; $display("FAIL ecb_enc: got %h/%b required %h/1", got, gl, C1); end
        cfg(K1, '0, 1'b0, 1'b1);
        send(C1, 1'b1); recv(0, got, gl);
        n_checks++;
        if (got !== P1) begin n_fail++; $display("FAIL ecb_dec: got %h required %h", got, P1); end
        cfg(K2, IV2, 1'b1, 1'b0);
        send(Q1, 1'b0); recv(1, got, gl);
        n_checks++;
        if ({got, gl} !== {D1, 1'b0}) begin n_fail++; $display("FAIL cbc_enc_b1: got %h/%b required %h/0", got, gl, D1); end
        send(Q2, 1'b1); recv(0, got, gl);
        n_checks++;
        if ({got, gl} !== {D2, 1'b1}) begin n_fail++; $display("FAIL cbc_enc_b2: got %h/%b required %h/1", got, gl, D2); end
        send(Q1, 1'b1); recv(0, got, gl);
        n_checks++;
        if (got !== D1) begin n_fail++; $display("FAIL cbc_chain_reload: got %h required %h", got, D1); end
        cfg(K2, IV2, 1'b1, 1'b1);
        send(D1, 1'b0); recv(2, got, gl);
        n_checks++;
        if (got !== Q1) begin n_fail++; $display("FAIL cbc_dec_b1: got %h required %h", got, Q1); end
        send(D2, 1'b1); recv(0, got, gl);
        n_checks++;
        if ({got, gl} !== {Q2, 1'b1}) begin n_fail++; $display("FAIL cbc_dec_b2: got %h/%b required %h/1", got, gl, Q2); end
    endtask

    task automatic test_random();
        logic [127:0] x, exp, got;
        logic         gl, l;
        int           nb;
        for (int c = 0; c < 6; c++) begin
            cfg(rnd128(), rnd128(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int msg = 0; msg < 2; msg++) begin
                nb = $urandom_range(1, 4);
                core_lat = $urandom_range(1, 12);
                for (int b = 0; b < nb; b++) begin
                    x = rnd128();
                    l = (b == nb - 1);
                    model_block(x, l, exp);
                    send(x, l);
                    recv($urandom_range(0, 3), got, gl);
                    n_checks++;
                    if (got !== exp) begin
                        n_fail++;
                        $display("FAIL random_data mode=%b dec=%b blk=%0d: got %h required %h", m_mode, m_dec, b, got, exp);
                    end
                    n_checks++;
                    if (gl !== l) begin n_fail++; $display("FAIL random_last blk=%0d: got %b required %b", b, gl, l); end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] x1, x2, e1, e2, d0, got;
        logic         gl;
        int           sc, n;
        core_lat = 4;
        cfg(rnd128(), '0, 1'b0, 1'b0);
        x1 = rnd128();
        model_block(x1, 1'b1, e1);
        send(x1, 1'b1);
        n = 0;
        while (OUT_VALID !== 1'b1 && n < 100) begin @(negedge CLK); n++; end
        sc = start_count;
        d0 = OUT_DATA;
        n_checks++;
        if (d0 !== e1) begin n_fail++; $display("FAIL bp_first: got %h required %h", d0, e1); end
        IN_VALID = 1'b1; IN_DATA = rnd128(); IN_LAST = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            CFG_LOAD = (i == 3);
            if (i == 3) begin KEY = rnd128(); MODE = 1'b1; ENCDEC = 1'b1; end
            #1;
            n_checks++;
            if ({OUT_VALID, IN_READY, OUT_DATA} !== {1'b1, 1'b0, d0}) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: got valid=%b ready=%b data=%h required 1 0 %h", i, OUT_VALID, IN_READY, OUT_DATA, d0);
            end
        end
        @(negedge CLK);
        CFG_LOAD = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
        @(negedge CLK);
        OUT_READY = 1'b0;
        n_checks++;
        if (start_count !== sc) begin n_fail++; $display("FAIL bp_no_restart: got %0d starts required %0d", start_count, sc); end
        x2 = rnd128();
        model_block(x2, 1'b1, e2);
        send(x2, 1'b1); recv(0, got, gl);
        n_checks++;
        if (got !== e2) begin n_fail++; $display("FAIL bp_cfg_ignored: got %h required %h", got, e2); end
    endtask

    task automatic test_cfg_collision();
        logic [127:0] k, x, e, got;
        logic         gl;
        int           sc;
        k = rnd128(); x = rnd128(); sc = start_count;
        @(negedge CLK);
        CFG_LOAD = 1'b1; KEY = k; IV = '0; MODE = 1'b0; ENCDEC = 1'b0;
        IN_VALID = 1'b1; IN_DATA = x; IN_LAST = 1'b1;
        #1;
        n_checks++;
        if (IN_READY !== 1'b0) begin n_fail++; $display("FAIL collision_ready: got %b required 0", IN_READY); end
        @(negedge CLK);
        CFG_LOAD = 1'b0;
        m_key = k; m_iv = '0; m_chain = '0; m_mode = 1'b0; m_dec = 1'b0;
        #1;
        n_checks++;
        if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL collision_ready_next: got %b required 1", IN_READY); end
        @(negedge CLK);
        IN_VALID = 1'b0;
        model_block(x, 1'b1, e);
        recv(0, got, gl);
        n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL collision_data: got %h required %h", got, e); end
        n_checks++;
        if (start_count !== sc + 1) begin n_fail++; $display("FAIL collision_starts: got %0d required %0d", start_count, sc + 1); end
    endtask

    task automatic test_spurious_done();
        logic [127:0] x, e, got;
        logic         gl;
        @(negedge CLK);
        CORE_DONE = 1'b1; CORE_TEXTOUT = rnd128();
        @(negedge CLK);
        CORE_DONE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({OUT_VALID, IN_READY} !== 2'b01) begin
                n_fail++;
                $display("FAIL spurious_done: got valid/ready=%b required 01", {OUT_VALID, IN_READY});
            end
            @(negedge CLK);
        end
        x = rnd128();
        model_block(x, 1'b1, e);
        send(x, 1'b1); recv(0, got, gl);
        n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL spurious_after: got %h required %h", got, e); end
    endtask

    task automatic test_throughput();
        logic [127:0] x, e;
        int           st[$];
        int           bad;
        core_lat = 4;
        bad = 0;
        cfg(rnd128(), '0, 1'b0, 1'b0);
        x = rnd128();
        model_block(x, 1'b1, e);
        OUT_READY = 1'b1;
        @(negedge CLK);
        IN_VALID = 1'b1; IN_DATA = x; IN_LAST = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge CLK);
            if (CORE_START === 1'b1) st.push_back(cyc);
            if (OUT_VALID === 1'b1 && OUT_DATA !== e) bad++;
        end
        IN_VALID = 1'b0;
        repeat (15) @(negedge CLK);
        OUT_READY = 1'b0;
        n_checks++;
        if (st.size() < 4) begin n_fail++; $display("FAIL tput_count: got %0d starts required >= 4", st.size()); end
        for (int i = 1; i < st.size(); i++) begin
            n_checks++;
            if (st[i] - st[i-1] !== core_lat + 3) begin
                n_fail++;
                $display("FAIL tput_period %0d: got %0d cycles required %0d", i, st[i] - st[i-1], core_lat + 3);
            end
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL tput_data: got %0d wrong outputs required 0", bad); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] k, iv, x, e, got;
        logic         gl;
        int           ov;
        k = rnd128(); iv = rnd128(); ov = 0;
        cfg(k, iv, 1'b1, 1'b0);
        core_lat = 20;
        send(rnd128(), 1'b0);
        repeat (5) @(negedge CLK);
        #2;
        nRST = 1'b0;
        #1;
        n_checks++;
        if ({IN_READY, OUT_VALID, ERR, CORE_START, CORE_ENCDEC, OUT_LAST, OUT_DATA, CORE_KEY, CORE_TEXTIN} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got flags=%b textin=%h required all zero",
                     {IN_READY, OUT_VALID, ERR, CORE_START, CORE_ENCDEC, OUT_LAST}, CORE_TEXTIN);
        end
        repeat (3) @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        n_checks++;
        if ({CORE_START, IN_READY} !== 2'b01) begin
            n_fail++;
            $display("FAIL midreset_release: got start/ready=%b required 01", {CORE_START, IN_READY});
        end
        for (int i = 0; i < 25; i++) begin
            @(negedge CLK);
            if (OUT_VALID !== 1'b0) ov++;
        end
        n_checks++;
        if (ov !== 0) begin n_fail++; $display("FAIL midreset_no_output: got %0d valid cycles required 0", ov); end
        core_lat = 3;
        cfg(k, iv, 1'b1, 1'b0);
        x = rnd128();
        model_block(x, 1'b1, e);
        send(x, 1'b1); recv(0, got, gl);
        n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL midreset_next_block: got %h required %h", got, e); end
    endtask

    task automatic test_timeout();
        logic [127:0] x, e, got;
        logic         gl;
        core_hang = 1'b1;
        cfg(rnd128(), '0, 1'b0, 1'b0);
        send(rnd128(), 1'b1);
        n_checks++;
        if (CORE_START !== 1'b1) begin n_fail++; $display("FAIL timeout_start: got %b required 1", CORE_START); end
        for (int k = 1; k <= int'(TIMEOUT); k++) begin
            @(negedge CLK);
            if (k == int'(TIMEOUT) - 1) begin
                n_checks++;
                if (ERR !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got ERR=%b at %0d cycles required 0", ERR, k); end
            end
            if (k == int'(TIMEOUT)) begin
                n_checks++;
                if (ERR !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got ERR=%b at %0d cycles required 1", ERR, k); end
            end
        end
        IN_VALID = 1'b1; OUT_READY = 1'b1; CORE_DONE = 1'b1;
        @(negedge CLK);
        CORE_DONE = 1'b0;
        repeat (5) @(negedge CLK);
        #1;
        n_checks++;
        if ({ERR, IN_READY, OUT_VALID} !== 3'b100) begin
            n_fail++;
            $display("FAIL error_sticky: got err/ready/valid=%b required 100", {ERR, IN_READY, OUT_VALID});
        end
        IN_VALID = 1'b0; OUT_READY = 1'b0;
        nRST = 1'b0;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        n_checks++;
        if ({ERR, IN_READY} !== 2'b01) begin n_fail++; $display("FAIL error_cleared: got err/ready=%b required 01", {ERR, IN_READY}); end
        core_hang = 1'b0;
        core_lat = 2;
        cfg(K1, '0, 1'b0, 1'b0);
        x = P1;
        model_block(x, 1'b1, e);
        send(x, 1'b1); recv(0, got, gl);
        n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL error_recovery: got %h required %h", got, e); end
    endtask

    initial begin
        nRST = 1'b0; CFG_LOAD = 1'b0; KEY = '0; IV = '0; MODE = 1'b0; ENCDEC = 1'b0;
        IN_VALID = 1'b0; IN_DATA = '0; IN_LAST = 1'b0; OUT_READY = 1'b0;
        m_key = '0; m_iv = '0; m_chain = '0; m_mode = 1'b0; m_dec = 1'b0;
        test_reset();
        test_vectors();
        test_random();
        test_backpressure();
        test_cfg_collision();
        test_spurious_done();
        test_throughput();
        test_reset_mid();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

endmodule
